// File: rtl/cam_val_pkg.sv
// Shared constants, count-width helper and address type for the CAM valid-bit store.
package cam_val_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef logic [ADDR_W_DEF-1:0] cam_addr_t;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Enabled ADDR_W-to-DEPTH one-hot decoder; out-of-range addresses decode to all-zero.
module onehot_decoder
  import cam_val_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  dec_c
);

  always_comb begin
    dec_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en && (addr == ADDR_W'(i))) dec_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cam_valid_array.sv
// Valid-bit store for the CAM: set/clear decode, registered row write-select and occupancy.
// Optional lowest-free-entry search is built when CAM_VAL_FREE_SEARCH_EN is defined.
module cam_valid_array
  import cam_val_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
  output logic [DEPTH-1:0]  wsel_o,
  output logic [DEPTH-1:0]  valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              oor_o
`ifdef CAM_VAL_FREE_SEARCH_EN
  ,
  output logic              free_vld_o,
  output logic [ADDR_W-1:0] free_idx_o
`endif
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] valid_n;
  logic [DEPTH-1:0] wsel_n;
  logic [CNT_W-1:0] count_n;
  logic             set_new;
  logic             clr_hit;
  logic             oor_n;

  onehot_decoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_set_dec (
    .en    (set_en),
    .addr  (set_addr),
    .dec_c (set_vec)
  );

  onehot_decoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr_dec (
    .en    (clr_en),
    .addr  (clr_addr),
    .dec_c (clr_vec)
  );

  // Set beats clear on the same row; count follows real bit transitions only.
  always_comb begin
    set_new = |(set_vec & ~valid_o);
    clr_hit = |(clr_vec & valid_o & ~set_vec);
    oor_n   = 1'b0;
    if (flush) begin
      valid_n = '0;
      wsel_n  = '0;
      count_n = '0;
    end else begin
      valid_n = (valid_o & ~clr_vec) | set_vec;
      wsel_n  = set_vec;
      count_n = count_o + CNT_W'(set_new) - CNT_W'(clr_hit);
      oor_n   = (set_en && (32'(set_addr) >= DEPTH)) ||
                (clr_en && (32'(clr_addr) >= DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= '0;
      wsel_o  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
      oor_o   <= 1'b0;
    end else begin
      valid_o <= valid_n;
      wsel_o  <= wsel_n;
      count_o <= count_n;
      full_o  <= (count_n == CNT_W'(DEPTH));
      empty_o <= (count_n == '0);
      oor_o   <= oor_n;
    end
  end

`ifdef CAM_VAL_FREE_SEARCH_EN
  // Lowest invalid row wins: scan from the top so the smallest index is written last.
  always_comb begin
    free_vld_o = 1'b0;
    free_idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_o[i]) begin
        free_vld_o = 1'b1;
        free_idx_o = ADDR_W'(i);
      end
    end
  end
`endif

endmodule
